// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the IF/ID pipeline record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } ifid_t;

  // IF/ID contents for an empty slot.
  function automatic ifid_t ifid_bubble(input word_t nop_word);
    ifid_t b;
    b.instr = nop_word;
    b.npc   = '0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and the IF/ID outputs.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  stall;
  logic  flush;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t instr;
  word_t npc;
  logic  valid;

  modport master (
    output imemREN, imemaddr, instr, npc, valid,
    input  ihit, imemload, stall, flush, redirect, redirect_pc, halt
  );

  modport slave (
    input  imemREN, imemaddr, instr, npc, valid,
    output ihit, imemload, stall, flush, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry IF/ID holding register that catches a word returned while decode is stalled.
module fetch_skid_buf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load_i,
  input  logic  clear_i,
  input  ifid_t data_i,
  output ifid_t data_o,
  output logic  full_o
);

  ifid_t data_q, data_d;
  logic  full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear_i) begin
      data_d = '0;
      full_d = 1'b0;
    end else if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register with stall, flush, redirect and halt.
// Optional skid buffer for words returned under stall: define FETCH_SKID_EN.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT  = 32'h0000_0000,
  parameter word_t NOP_WORD = 32'h0000_0000
) (
  input logic           CLK,
  input logic           nRST,
  fetch_stage_if.master bus
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  ifid_t        ifid_q, ifid_d;
  word_t        pc_plus4;
  ifid_t        bubble;
  ifid_t        fetched;
  logic         eff_stall;

  assign pc_plus4  = pc_q + PC_STEP;
  assign bubble    = ifid_bubble(NOP_WORD);
  assign eff_stall = bus.stall & ~bus.flush;

  always_comb begin
    fetched.instr = bus.imemload;
    fetched.npc   = pc_plus4;
    fetched.valid = 1'b1;
  end

`ifdef FETCH_SKID_EN
  logic  skid_load, skid_clear, skid_full;
  ifid_t skid_data;

  fetch_skid_buf u_skid (
    .CLK     (CLK),
    .nRST    (nRST),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (fetched),
    .data_o  (skid_data),
    .full_o  (skid_full)
  );
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
`ifdef FETCH_SKID_EN
    skid_load  = 1'b0;
    skid_clear = 1'b0;
`endif
    if (bus.halt) begin
      state_d = HALTED;
      ifid_d  = bubble;
`ifdef FETCH_SKID_EN
      skid_clear = 1'b1;
`endif
    end else if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (bus.redirect) begin
      // The word returned this cycle belongs to the wrong path and is dropped.
      pc_d    = bus.redirect_pc;
      ifid_d  = bubble;
      state_d = FETCH;
`ifdef FETCH_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      if (eff_stall) begin
        if (state_q == FETCH && bus.ihit) begin
`ifdef FETCH_SKID_EN
          skid_load = 1'b1;
          pc_d      = pc_plus4;
          state_d   = HOLD;
`endif
        end
`ifdef FETCH_SKID_EN
      end else if (state_q == HOLD) begin
        // PC already moved past the buffered word when it was captured.
        ifid_d     = skid_full ? skid_data : bubble;
        skid_clear = 1'b1;
        state_d    = FETCH;
`endif
      end else if (bus.ihit) begin
        ifid_d = fetched;
        pc_d   = pc_plus4;
      end else begin
        ifid_d = bubble;
      end
      if (bus.flush) begin
        ifid_d = bubble;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      ifid_q  <= ifid_bubble(NOP_WORD);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  assign bus.imemREN  = (state_q == FETCH);
  assign bus.imemaddr = pc_q;
  assign bus.instr    = ifid_q.instr;
  assign bus.npc      = ifid_q.npc;
  assign bus.valid    = ifid_q.valid;

endmodule
